// File: rtl/mult_arbiter.sv
// Four-requester round-robin front end for one shared sequential signed 8x8 multiplier.
// One multiplication is in flight at a time; a stalled multiplier is aborted after TIMEOUT WAIT cycles.
module mult_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req_valid,
    output logic [3:0]  req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_id,
    output logic [15:0] rsp_prod,
    output logic        rsp_timeout,
    output logic        m_start,
    output logic [7:0]  m_mc,
    output logic [7:0]  m_mp,
    input  logic        m_busy,
    input  logic [15:0] m_prod
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]  state_r;
    logic [1:0]  last_grant_r;
    logic [1:0]  id_r;
    logic [4:0]  cnt_r;
    logic [7:0]  op_a_r;
    logic [7:0]  op_b_r;
    logic [15:0] prod_r;
    logic        timeout_r;
    logic        start_r;
    logic        rsp_valid_r;
    logic [1:0]  grant_idx_s;
    logic        grant_vld_s;
    logic [3:0]  ready_s;
    logic        accept_s;

    // Highest priority is last+1; scanning from lowest to highest priority lets the best one win.
    function automatic logic [2:0] rr_pick(input logic [3:0] valid, input logic [1:0] last);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (valid[idx]) begin
                pick = {1'b1, idx};
            end
        end
        return pick;
    endfunction

    // Round-robin winner among the currently valid requesters
    always_comb begin
        {grant_vld_s, grant_idx_s} = rr_pick(req_valid, last_grant_r);
    end

    // Combinational grant, only offered while idle
    always_comb begin
        ready_s = 4'b0000;
        if ((state_r == IDLE) && grant_vld_s) begin
            ready_s = 4'b0001 << grant_idx_s;
        end else begin
            ready_s = 4'b0000;
        end
    end

    assign accept_s = |(req_valid & ready_s);

    // Arbitration / issue / wait / response sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_grant_r <= 2'd3;
            id_r         <= 2'd0;
            cnt_r        <= 5'd0;
            op_a_r       <= 8'd0;
            op_b_r       <= 8'd0;
            prod_r       <= 16'd0;
            timeout_r    <= 1'b0;
            start_r      <= 1'b0;
            rsp_valid_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_a_r       <= req_a[{grant_idx_s, 3'b000} +: 8];
                        op_b_r       <= req_b[{grant_idx_s, 3'b000} +: 8];
                        id_r         <= grant_idx_s;
                        last_grant_r <= grant_idx_s;
                        start_r      <= 1'b1;
                        state_r      <= ISSUE;
                    end
                end
                ISSUE: begin
                    start_r <= 1'b0;
                    cnt_r   <= 5'd1;
                    state_r <= WAIT;
                end
                WAIT: begin
                    // Completion takes precedence over the abort in the same cycle
                    if (!m_busy) begin
                        prod_r      <= m_prod;
                        timeout_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        state_r     <= RESP;
                    end else if (cnt_r >= 5'(TIMEOUT)) begin
                        prod_r      <= 16'd0;
                        timeout_r   <= 1'b1;
                        rsp_valid_r <= 1'b1;
                        state_r     <= RESP;
                    end else begin
                        cnt_r <= cnt_r + 5'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        cnt_r       <= 5'd0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    start_r     <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = ready_s;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_id      = id_r;
    assign rsp_prod    = prod_r;
    assign rsp_timeout = timeout_r;
    assign m_start     = start_r;
    assign m_mc        = op_a_r;
    assign m_mp        = op_b_r;

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 15, maximum WAIT cycles before abort (range 9..31).
REQ-002 Port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_n  in  1  asynchronous active-low reset.
REQ-004 Port: req_valid  in  4  per-requester request strobe, bit i = requester i.
REQ-005 Port: req_ready  out  4  per-requester accept, at most one bit high.
REQ-006 Port: req_a  in  32  packed multiplicands, requester i at bits [8i+7:8i], signed.
REQ-007 Port: req_b  in  32  packed multipliers, same packing, signed.
REQ-008 Port: rsp_valid  out  1  response available.
REQ-009 Port: rsp_ready  in  1  response consumer accept.
REQ-010 Port: rsp_id  out  2  index of requester owning the response.
REQ-011 Port: rsp_prod  out  16  signed product.
REQ-012 Port: rsp_timeout  out  1  response is an abort, rsp_prod = 0.
REQ-013 Port: m_start  out  1  start strobe to the shared sequential Booth multiplier.
REQ-014 Port: m_mc, m_mp  out  8 each  multiplier operands.
REQ-015 Port: m_busy  in  1  multiplier busy (high while iterating).
REQ-016 Port: m_prod  in  16  multiplier product.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; one multiplication in flight at a time.
REQ-018 IDLE: if any req_valid, the block SHALL grant by round-robin starting at (last_grant+1) mod 4, asserting req_ready for the winner combinationally in the same cycle.
REQ-019 Accept = req_valid[i] & req_ready[i] at a rising edge; the block SHALL latch req_a/req_b slice i and id i, set last_grant = i, and go to ISSUE.
REQ-020 req_ready SHALL be 0 in every state except IDLE; a requester dropping req_valid before accept SHALL be neither granted nor penalised.
REQ-021 ISSUE: m_start = 1 for exactly one cycle, m_mc/m_mp = latched operands; next state WAIT.
REQ-022 m_mc/m_mp SHALL hold the latched operands from ISSUE until leaving WAIT; m_start SHALL be 0 in all other states.
REQ-023 WAIT: 5-bit cycle counter starts at 1 on entry; first cycle with m_busy = 0 SHALL capture m_prod into rsp_prod, rsp_timeout = 0, go RESP.
REQ-024 WAIT: if counter reaches TIMEOUT with m_busy still 1, the block SHALL go RESP with rsp_prod = 0, rsp_timeout = 1.
REQ-025 m_busy SHALL be ignored outside WAIT; a low m_busy in the first WAIT cycle SHALL still be honoured.
REQ-026 RESP: rsp_valid = 1, rsp_id/rsp_prod/rsp_timeout stable until rsp_valid & rsp_ready at an edge, then IDLE.
REQ-027 rsp_ready while rsp_valid = 0 SHALL have no effect; a new grant SHALL occur no earlier than the IDLE cycle after response handshake.
REQ-028 rsp_prod SHALL be m_prod unmodified (16-bit two's complement product of signed 8-bit operands).
REQ-029 Latency with the team multiplier (busy low 8 cycles after start deasserts): accept in cycle T -> ISSUE T+1 -> capture in T+10 -> rsp_valid first high in T+11.
REQ-030 Round-robin pointer SHALL advance only on accept, never on timeout or idle cycles.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, last_grant = 3 (requester 0 highest priority first), counter = 0.
REQ-032 During and after reset: req_ready = 0000 (until IDLE evaluates), rsp_valid = 0, rsp_id = 0, rsp_prod = 0, rsp_timeout = 0, m_start = 0, m_mc = m_mp = 0.
REQ-033 Reset mid-WAIT or mid-RESP SHALL discard the in-flight operation with no response; the multiplier is not otherwise notified.

Verification
REQ-034 Single request: req 0 a=30 b=13, rsp_ready=1 -> rsp_valid at T+11, rsp_id=0, rsp_prod=390, rsp_timeout=0.
REQ-035 Signed: req 2 a=-3 b=5 -> rsp_prod=16'hFFF1 (-15); a=-7 b=-9 -> rsp_prod=63.
REQ-036 Fairness: all four req_valid held high after reset, rsp_ready=1 -> grant order 0,1,2,3,0; each product correct.
REQ-037 Backpressure: rsp_ready=0 for 20 cycles after rsp_valid -> rsp outputs stable, req_ready stays 0000, no m_start; release -> next grant following IDLE cycle.
REQ-038 Timeout: m_busy tied high, TIMEOUT=15 -> rsp_valid after 15 WAIT cycles, rsp_timeout=1, rsp_prod=0, pointer advanced once.
REQ-039 Reset mid-WAIT: assert rst_n=0 at T+5 -> all outputs zero immediately, no response; after release, requester 0 wins first.
